// File: rtl/window_scan_ctrl.sv
// Frame sequencer for the 3x3 line-buffer window generator: clear, prime, raster scan, flush.
// Optional prime timeout enabled by defining WSC_PRIME_TIMEOUT_EN.
module window_scan_ctrl #(
  parameter int unsigned IMG_W     = 712,
  parameter int unsigned IMG_H     = 712,
  parameter int unsigned CLR_CYC   = 4,
  parameter int unsigned PRIME_TMO = 4096
) (
  input  logic       gen_clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  output logic       buf_rst,
  input  logic       buf_rdy,
  output logic       buf_rd,
  input  logic       dn_ready,
  output logic       win_valid,
  output logic [9:0] win_row,
  output logic [9:0] win_col,
  output logic       sof,
  output logic       eol,
  output logic       eof,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int unsigned CW    = 10;
  localparam int unsigned CLR_W = (CLR_CYC > 1) ? $clog2(CLR_CYC) : 1;
  localparam logic [CW-1:0]    COL_LAST = CW'(IMG_W - 1);
  localparam logic [CW-1:0]    ROW_LAST = CW'(IMG_H - 1);
  localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLR_CYC - 1);

  if (CLR_CYC < 1 || PRIME_TMO < 1 || IMG_W < 1 || IMG_W > 1024 ||
      IMG_H < 1 || IMG_H > 1024) begin : g_cfg_check
    $error("window_scan_ctrl: illegal parameter set");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_PRIME,
    S_SCAN,
    S_FLUSH
  } state_t;

  state_t            state;
  logic              scan_en;
  logic [CW-1:0]     row;
  logic [CW-1:0]     col;
  logic [CLR_W-1:0]  clr_cnt;
  logic              at_eol;
  logic              at_last;

`ifdef WSC_PRIME_TIMEOUT_EN
  localparam int unsigned TMO_W = (PRIME_TMO > 1) ? $clog2(PRIME_TMO) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(PRIME_TMO - 1);
  logic [TMO_W-1:0] tmo_cnt;
`else
  assign err = 1'b0;
`endif

  // Registered enable gated by downstream ready: one window per read strobe.
  assign buf_rd  = scan_en & dn_ready;
  assign at_eol  = (col == COL_LAST);
  assign at_last = at_eol & (row == ROW_LAST);

  always_ff @(posedge gen_clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      buf_rst   <= 1'b1;
      scan_en   <= 1'b0;
      row       <= '0;
      col       <= '0;
      clr_cnt   <= '0;
      win_valid <= 1'b0;
      win_row   <= '0;
      win_col   <= '0;
      sof       <= 1'b0;
      eol       <= 1'b0;
      eof       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef WSC_PRIME_TIMEOUT_EN
      err       <= 1'b0;
      tmo_cnt   <= '0;
`endif
    end else begin
      // Window tag pipeline mirrors the buffer's one-cycle output register.
      done      <= 1'b0;
      win_valid <= buf_rd;
      sof       <= buf_rd & (row == '0) & (col == '0);
      eol       <= buf_rd & at_eol;
      eof       <= buf_rd & at_last;
      if (buf_rd) begin
        win_row <= row;
        win_col <= col;
      end

      if (abort && state != S_IDLE) begin
        state     <= S_IDLE;
        buf_rst   <= 1'b1;
        scan_en   <= 1'b0;
        busy      <= 1'b0;
        win_valid <= 1'b0;
        sof       <= 1'b0;
        eol       <= 1'b0;
        eof       <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start && !abort) begin
              state   <= S_CLR;
              clr_cnt <= '0;
              busy    <= 1'b1;
`ifdef WSC_PRIME_TIMEOUT_EN
              err     <= 1'b0;
`endif
            end
          end
          S_CLR: begin
            if (clr_cnt == CLR_LAST) begin
              state   <= S_PRIME;
              buf_rst <= 1'b0;
`ifdef WSC_PRIME_TIMEOUT_EN
              tmo_cnt <= '0;
`endif
            end else begin
              clr_cnt <= clr_cnt + 1'b1;
            end
          end
          S_PRIME: begin
            if (buf_rdy) begin
              state   <= S_SCAN;
              scan_en <= 1'b1;
              row     <= '0;
              col     <= '0;
            end
`ifdef WSC_PRIME_TIMEOUT_EN
            else if (tmo_cnt == TMO_LAST) begin
              state   <= S_IDLE;
              buf_rst <= 1'b1;
              busy    <= 1'b0;
              err     <= 1'b1;
            end else begin
              tmo_cnt <= tmo_cnt + 1'b1;
            end
`endif
          end
          S_SCAN: begin
            if (buf_rd) begin
              if (at_last) begin
                row     <= '0;
                col     <= '0;
                scan_en <= 1'b0;
                state   <= S_FLUSH;
              end else if (at_eol) begin
                col <= '0;
                row <= row + 1'b1;
              end else begin
                col <= col + 1'b1;
              end
            end
          end
          S_FLUSH: begin
            state   <= S_IDLE;
            buf_rst <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b1;
          end
          default: begin
            state   <= S_IDLE;
            buf_rst <= 1'b1;
            scan_en <= 1'b0;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_window_scan_ctrl.sv
// Bench for window_scan_ctrl at IMG_W=4, IMG_H=3, CLR_CYC=2, PRIME_TMO=8.
// Define WSC_PRIME_TIMEOUT_EN for both files to exercise the prime timeout.
module tb_window_scan_ctrl;

  localparam int W = 4;
  localparam int H = 3;
  localparam int N = W * H;

  logic       gen_clk;
  logic       rst;
  logic       start;
  logic       abort;
  logic       buf_rst;
  logic       buf_rdy;
  logic       buf_rd;
  logic       dn_ready;
  logic       win_valid;
  logic [9:0] win_row;
  logic [9:0] win_col;
  logic       sof;
  logic       eol;
  logic       eof;
  logic       busy;
  logic       done;
  logic       err;

  window_scan_ctrl #(
    .IMG_W(W), .IMG_H(H), .CLR_CYC(2), .PRIME_TMO(8)
  ) dut (
    .gen_clk(gen_clk), .rst(rst), .start(start), .abort(abort),
    .buf_rst(buf_rst), .buf_rdy(buf_rdy), .buf_rd(buf_rd), .dn_ready(dn_ready),
    .win_valid(win_valid), .win_row(win_row), .win_col(win_col),
    .sof(sof), .eol(eol), .eof(eof), .busy(busy), .done(done), .err(err)
  );

  initial gen_clk = 1'b0;
  always #5 gen_clk = ~gen_clk;

  int n_cmp = 0;
  int n_err = 0;
  int rd_cnt, win_idx, done_cnt;
  logic prev_rd, prev_abort, prev_eofv;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected window tag for the k-th window of a frame in raster order.
  function automatic logic [22:0] exp_win(input int k);
    int r, c;
    r = k / W;
    c = k % W;
    return {10'(r), 10'(c), 1'(k == 0), 1'(c == W - 1), 1'(k == N - 1)};
  endfunction

  task automatic sample();
    @(negedge gen_clk);
    chk("win_latency", 32'(win_valid), 32'(prev_rd && !prev_abort));
    chk("done_latency", 32'(done), 32'(prev_eofv && !prev_abort));
    if (buf_rd) begin
      chk("rd_gated_by_ready", 32'(dn_ready), 32'd1);
      rd_cnt++;
    end
    if (win_valid) begin
      chk("win_tag", 32'({win_row, win_col, sof, eol, eof}), 32'(exp_win(win_idx)));
      win_idx++;
    end
    if (done) done_cnt++;
  endtask

  task automatic advance();
    prev_rd    = buf_rd;
    prev_abort = abort;
    prev_eofv  = win_valid && eof;
    @(posedge gen_clk);
    #1;
  endtask

  task automatic clear_hist();
    prev_rd = 1'b0; prev_abort = 1'b0; prev_eofv = 1'b0;
  endtask

  // start, clear phase; leaves the bench at PRIME cycle 1 (sampled, not advanced).
  task automatic begin_frame(output int clr);
    rd_cnt = 0; win_idx = 0; done_cnt = 0; clr = 0;
    buf_rdy = 1'b0;
    start = 1'b1;
    sample();
    advance();
    start = 1'b0;
    sample();
    chk("err_cleared_by_start", 32'(err), 32'd0);
    for (int i = 0; i < 20 && busy && buf_rst; i++) begin
      clr++;
      advance();
      sample();
    end
  endtask

  // mode 0: ready always, 1: toggle, 2: random.
  task automatic run_frame(input int mode, input int rdy_dly, input int abort_at,
                           input int rst_at, input bit spam);
    int  clr;
    bit  fin;
    bit  aborted;
    bit  was_rst;
    begin_frame(clr);
    chk("clr_cycles", 32'(clr), 32'd2);
    chk("prime_buf_rst_low", 32'(buf_rst), 32'd0);
    advance();
    for (int i = 1; i < rdy_dly; i++) begin
      sample();
      chk("prime_no_rd", 32'(buf_rd), 32'd0);
      advance();
    end
    buf_rdy = 1'b1;
    sample();
    advance();
    fin = 1'b0; aborted = 1'b0; was_rst = 1'b0;
    for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
      dn_ready = (mode == 0) ? 1'b1 : (mode == 1) ? 1'(cyc % 2 == 0) : 1'($urandom_range(0, 1));
      start    = spam && rd_cnt < 8 && $urandom_range(0, 2) == 0;
      if (cyc > 0) buf_rdy = 1'($urandom_range(0, 1));
      sample();
      if (cyc == 0 && mode == 0) chk("first_rd_latency", 32'(buf_rd), 32'd1);
      if (rst_at != 0 && rd_cnt == rst_at) begin
        #2 rst = 1'b1;
        #1;
        chk("async_rst_buf_rst", 32'(buf_rst), 32'd1);
        chk("async_rst_outs", 32'({buf_rd, win_valid, sof, eol, eof, busy, done}), 32'd0);
        @(posedge gen_clk);
        #1 rst = 1'b0;
        clear_hist();
        start = 1'b0;
        fin = 1'b1; was_rst = 1'b1;
      end else begin
        if (abort_at != 0 && buf_rd && rd_cnt == abort_at) abort = 1'b1;
        if (done) fin = 1'b1;
        advance();
        if (abort) begin
          abort = 1'b0;
          start = 1'b0;
          sample();
          chk("abort_idle", 32'({busy, buf_rst, buf_rd}), 32'b010);
          advance();
          fin = 1'b1; aborted = 1'b1;
        end
      end
    end
    start = 1'b0;
    chk("frame_ended", 32'(fin), 32'd1);
    if (!was_rst) begin
      for (int i = 0; i < 3; i++) begin
        sample();
        chk("idle_after_frame", 32'({busy, buf_rst, buf_rd}), 32'b010);
        advance();
      end
      chk("done_count", 32'(done_cnt), aborted ? 32'd0 : 32'd1);
      if (!aborted) begin
        chk("rd_count", 32'(rd_cnt), 32'(N));
        chk("win_count", 32'(win_idx), 32'(N));
        chk("err_idle", 32'(err), 32'd0);
      end
    end
  endtask

`ifdef WSC_PRIME_TIMEOUT_EN
  task automatic prime_timeout();
    int clr;
    int prime;
    begin_frame(clr);
    chk("tmo_clr_cycles", 32'(clr), 32'd2);
    prime = 1;
    advance();
    for (int i = 0; i < 50; i++) begin
      sample();
      if (!busy) break;
      prime++;
      advance();
    end
    chk("tmo_prime_cycles", 32'(prime), 32'd8);
    chk("tmo_err", 32'(err), 32'd1);
    chk("tmo_no_rd", 32'(rd_cnt), 32'd0);
    chk("tmo_no_done", 32'(done_cnt), 32'd0);
    advance();
    repeat (3) begin sample(); advance(); end
    sample();
    chk("tmo_err_sticky", 32'({err, busy, buf_rst}), 32'b101);
    advance();
  endtask
`endif

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; buf_rdy = 1'b0; dn_ready = 1'b0;
    clear_hist();
    rd_cnt = 0; win_idx = 0; done_cnt = 0;
    repeat (2) @(posedge gen_clk);
    #1;
    chk("reset_buf_rst", 32'(buf_rst), 32'd1);
    chk("reset_outs", 32'({buf_rd, win_valid, win_row, win_col, sof, eol, eof, busy, done, err}), 32'd0);
    rst = 1'b0;
    advance();

    run_frame(0, 3, 0, 0, 1'b0);
    run_frame(1, 2, 0, 0, 1'b0);
    run_frame(0, 1, 6, 0, 1'b0);
    run_frame(2, 3, 0, 0, 1'b0);
    run_frame(2, int'($urandom_range(1, 5)), 0, 0, 1'b1);
    run_frame(0, 2, 0, 5, 1'b0);
    run_frame(2, 2, 0, 0, 1'b0);
`ifdef WSC_PRIME_TIMEOUT_EN
    prime_timeout();
    run_frame(2, 5, 0, 0, 1'b0);
`else
    run_frame(2, 15, 0, 0, 1'b0);
`endif
    for (int f = 0; f < 4; f++)
      run_frame(2, int'($urandom_range(1, 6)), 0, 0, 1'($urandom_range(0, 1)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
